// File: rtl/wb_mtimer_if.sv
// rtl/wb_mtimer_if.sv - Wishbone B3 classic bus bundle for the machine timer
//
// Purpose: groups the Wishbone request/response signals seen by wb_mtimer.
// Signals (directions as seen by the slave):
//   wb_adr_i  [2:0]  word address (intercon adr[4:2])
//   wb_dat_i  [31:0] write data
//   wb_sel_i  [3:0]  byte enables
//   wb_we_i          write enable
//   wb_cyc_i         bus cycle
//   wb_stb_i         strobe
//   wb_dat_o  [31:0] read data, valid with ack
//   wb_ack_o         transfer acknowledge
//   wb_err_o         error acknowledge
interface wb_mtimer_if;
  logic [2:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_mtimer.sv
// rtl/wb_mtimer.sv - Wishbone RISC-V machine timer with prescaler and level IRQ
//
// Purpose: 64-bit mtime/mtimecmp timer on a Wishbone B3 classic slave port.
// Ports:
//   wb_clk_i   system clock
//   wb_rst_ni  asynchronous active-low reset
//   wb         Wishbone slave bundle (wb_mtimer_if.slave)
//   irq_o      timer interrupt, level, registered
// Register map (word address):
//   0 MTIME_LO  1 MTIME_HI (reads shadow)  2 MTIMECMP_LO  3 MTIMECMP_HI
//   4 CTRL {IRQ_EN, EN}  5 PRESCALE  6 STATUS {PENDING} ro  7 unmapped -> err
module wb_mtimer #(
  parameter int          PRESCALE_W = 16,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  wb_mtimer_if.slave wb,
  output logic       irq_o
);

  localparam logic [2:0] A_MTIME_LO = 3'd0;
  localparam logic [2:0] A_MTIME_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO   = 3'd2;
  localparam logic [2:0] A_CMP_HI   = 3'd3;
  localparam logic [2:0] A_CTRL     = 3'd4;
  localparam logic [2:0] A_PRESCALE = 3'd5;
  localparam logic [2:0] A_STATUS   = 3'd6;
  localparam logic [2:0] A_UNMAPPED = 3'd7;

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic [1:0]            ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pcnt;
  logic [31:0]           hi_shadow;

  logic        req;
  logic        wr;
  logic        rd;
  logic        tick;
  logic        cmp_ge;
  logic [63:0] mtime_inc;
  logic [63:0] mtime_next;
  logic [31:0] rdata;
  logic [31:0] cmp_lo_wr;
  logic [31:0] cmp_hi_wr;
  logic [31:0] ctrl_wr;
  logic [31:0] prescale_wr;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int n = 0; n < 4; n++) begin
      res[8*n +: 8] = sel[n] ? new_val[8*n +: 8] : old_val[8*n +: 8];
    end
    return res;
  endfunction

  // A request is only seen while no response is outstanding, which forces
  // one idle cycle between back-to-back transfers.
  assign req = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o & ~wb.wb_err_o;
  assign wr  = req & wb.wb_we_i;
  assign rd  = req & ~wb.wb_we_i;

  assign tick      = ctrl[0] & (pcnt == prescale);
  assign mtime_inc = mtime + 64'(tick);
  assign cmp_ge    = (mtime >= mtimecmp);

  assign cmp_lo_wr   = lane_merge(mtimecmp[31:0], wb.wb_dat_i, wb.wb_sel_i);
  assign cmp_hi_wr   = lane_merge(mtimecmp[63:32], wb.wb_dat_i, wb.wb_sel_i);
  assign ctrl_wr     = lane_merge(32'(ctrl), wb.wb_dat_i, wb.wb_sel_i);
  assign prescale_wr = lane_merge(32'(prescale), wb.wb_dat_i, wb.wb_sel_i);

  // Written lanes override the incremented value so a write in a tick cycle
  // lands exactly as written; unwritten lanes keep counting.
  always_comb begin
    mtime_next = mtime_inc;
    if (wr && wb.wb_adr_i == A_MTIME_LO) begin
      mtime_next[31:0] = lane_merge(mtime_inc[31:0], wb.wb_dat_i, wb.wb_sel_i);
    end else if (wr && wb.wb_adr_i == A_MTIME_HI) begin
      mtime_next[63:32] = lane_merge(mtime_inc[63:32], wb.wb_dat_i, wb.wb_sel_i);
    end
  end

  always_comb begin
    rdata = '0;
    case (wb.wb_adr_i)
      A_MTIME_LO: rdata = mtime[31:0];
      A_MTIME_HI: rdata = hi_shadow;
      A_CMP_LO:   rdata = mtimecmp[31:0];
      A_CMP_HI:   rdata = mtimecmp[63:32];
      A_CTRL:     rdata = 32'(ctrl);
      A_PRESCALE: rdata = 32'(prescale);
      A_STATUS:   rdata = 32'(cmp_ge);
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      mtime       <= '0;
      mtimecmp    <= CMP_RESET;
      ctrl        <= '0;
      prescale    <= '0;
      pcnt        <= '0;
      hi_shadow   <= '0;
      wb.wb_dat_o <= '0;
      wb.wb_ack_o <= 1'b0;
      wb.wb_err_o <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      mtime <= mtime_next;

      if (!ctrl[0] || tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PRESCALE_W'(1);
      end

      if (wr) begin
        case (wb.wb_adr_i)
          A_CMP_LO:   mtimecmp[31:0]  <= cmp_lo_wr;
          A_CMP_HI:   mtimecmp[63:32] <= cmp_hi_wr;
          A_CTRL:     ctrl            <= ctrl_wr[1:0];
          A_PRESCALE: prescale        <= prescale_wr[PRESCALE_W-1:0];
          default:    ;
        endcase
      end

      // Snapshot the live high word with the low-word read so the following
      // HI read pairs with it, even if a carry happens in between.
      if (rd && wb.wb_adr_i == A_MTIME_LO) begin
        hi_shadow <= mtime[63:32];
      end

      wb.wb_ack_o <= req & (wb.wb_adr_i != A_UNMAPPED);
      wb.wb_err_o <= req & (wb.wb_adr_i == A_UNMAPPED);
      wb.wb_dat_o <= (rd && wb.wb_adr_i != A_UNMAPPED) ? rdata : '0;

      irq_o <= ctrl[1] & cmp_ge;
    end
  end

endmodule

// File: tb/tb_wb_mtimer.sv
// tb/tb_wb_mtimer.sv - self-checking bench for wb_mtimer
module tb_wb_mtimer;

  logic clk = 1'b0;
  logic rst_n;
  logic irq;

  always #5 clk = ~clk;

  wb_mtimer_if bus();

  wb_mtimer #(.PRESCALE_W(16), .CMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb       (bus),
    .irq_o    (irq)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] RST_VALS [7] = '{32'h0, 32'h0, 32'hFFFF_FFFF,
                                           32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};

  // Called at posedge+1; returns at posedge+1 two cycles later.
  task automatic bus_xfer(input logic [2:0] adr, input logic we,
                          input logic [31:0] dat, input logic [3:0] sel,
                          output logic [31:0] rdat, output logic ack,
                          output logic err);
    bus.wb_adr_i = adr;
    bus.wb_we_i  = we;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    rdat = bus.wb_dat_o;
    ack  = bus.wb_ack_o;
    err  = bus.wb_err_o;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] adr, input logic [31:0] dat);
    logic [31:0] d;
    logic a, e;
    bus_xfer(adr, 1'b1, dat, 4'hF, d, a, e);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [31:0] d, exp;
    logic a, e;
    n_checks++;
    if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0 || irq !== 1'b0 || bus.wb_dat_o !== 32'h0) begin
      $display("FAIL reset_outputs: ack=%b err=%b irq=%b dat=%h, required all 0",
               bus.wb_ack_o, bus.wb_err_o, irq, bus.wb_dat_o);
    end else n_pass++;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(RST_VALS[i]);
      bus_xfer(3'(i), 1'b0, 32'h0, 4'hF, d, a, e);
      exp = exp_q.pop_front();
      n_checks++;
      if (d !== exp || a !== 1'b1 || e !== 1'b0) begin
        $display("FAIL reset_read[%0d]: dat=%h ack=%b err=%b, required dat=%h ack=1 err=0",
                 i, d, a, e, exp);
      end else n_pass++;
    end
  endtask

  task automatic test_byte_lane;
    logic [31:0] d, exp;
    logic a, e;
    bus_xfer(3'd2, 1'b1, 32'h0000_AB00, 4'b0010, d, a, e);
    exp_q.push_back(32'hFFFF_ABFF);
    bus_xfer(3'd2, 1'b0, 32'h0, 4'hF, d, a, e);
    exp = exp_q.pop_front();
    n_checks++;
    if (d !== exp) $display("FAIL byte_lane_cmp_lo: got %h required %h", d, exp);
    else n_pass++;
    exp_q.push_back(32'hFFFF_FFFF);
    bus_xfer(3'd3, 1'b0, 32'h0, 4'hF, d, a, e);
    exp = exp_q.pop_front();
    n_checks++;
    if (d !== exp) $display("FAIL byte_lane_cmp_hi: got %h required %h", d, exp);
    else n_pass++;
    bus_xfer(3'd6, 1'b1, 32'hFFFF_FFFF, 4'hF, d, a, e);
    n_checks++;
    if (a !== 1'b1 || e !== 1'b0) $display("FAIL status_write_ack: ack=%b err=%b required ack=1 err=0", a, e);
    else n_pass++;
    exp_q.push_back(32'h0);
    bus_xfer(3'd6, 1'b0, 32'h0, 4'hF, d, a, e);
    exp = exp_q.pop_front();
    n_checks++;
    if (d !== exp) $display("FAIL status_after_write: got %h required %h", d, exp);
    else n_pass++;
  endtask

  task automatic test_count;
    logic [31:0] d, exp;
    logic a, e;
    wr(3'd5, 32'd3);
    wr(3'd4, 32'd1);
    repeat (39) begin @(posedge clk); #1; end
    exp_q.push_back(32'd10);
    bus_xfer(3'd0, 1'b0, 32'h0, 4'hF, d, a, e);
    exp = exp_q.pop_front();
    n_checks++;
    if (d !== exp) $display("FAIL count_prescale3: got %0d required %0d", d, exp);
    else n_pass++;
    wr(3'd4, 32'd0);
    repeat (20) begin @(posedge clk); #1; end
    exp_q.push_back(32'd10);
    bus_xfer(3'd0, 1'b0, 32'h0, 4'hF, d, a, e);
    exp = exp_q.pop_front();
    n_checks++;
    if (d !== exp) $display("FAIL count_frozen: got %0d required %0d", d, exp);
    else n_pass++;
  endtask

  task automatic test_wrap;
    logic [31:0] d, exp;
    logic a, e;
    wr(3'd5, 32'd0);
    wr(3'd0, 32'hFFFF_FFFE);
    wr(3'd1, 32'h0);
    wr(3'd4, 32'd1);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0003);
    exp_q.push_back(32'h0000_0001);
    for (int i = 0; i < 4; i++) begin
      bus_xfer((i % 2 == 0) ? 3'd0 : 3'd1, 1'b0, 32'h0, 4'hF, d, a, e);
      exp = exp_q.pop_front();
      n_checks++;
      if (d !== exp) $display("FAIL wrap_read[%0d]: got %h required %h", i, d, exp);
      else n_pass++;
    end
    wr(3'd4, 32'd0);
  endtask

  task automatic test_irq;
    logic [31:0] d, exp;
    logic a, e;
    int cnt;
    wr(3'd0, 32'h50);
    wr(3'd1, 32'h0);
    wr(3'd2, 32'h64);
    wr(3'd3, 32'h0);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL irq_disabled: got %b required 0", irq);
    else n_pass++;
    wr(3'd4, 32'd3);
    cnt = 0;
    while (irq !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_checks++;
    if (cnt !== 20) $display("FAIL irq_rise_cycles: got %0d required 20", cnt);
    else n_pass++;
    exp_q.push_back(32'h1);
    bus_xfer(3'd6, 1'b0, 32'h0, 4'hF, d, a, e);
    exp = exp_q.pop_front();
    n_checks++;
    if (d !== exp) $display("FAIL status_pending: got %h required %h", d, exp);
    else n_pass++;
    bus_xfer(3'd2, 1'b1, 32'h1000, 4'hF, d, a, e);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL irq_drop: got %b required 0", irq);
    else n_pass++;
    exp_q.push_back(32'h0);
    bus_xfer(3'd6, 1'b0, 32'h0, 4'hF, d, a, e);
    exp = exp_q.pop_front();
    n_checks++;
    if (d !== exp) $display("FAIL status_cleared: got %h required %h", d, exp);
    else n_pass++;
    wr(3'd4, 32'd0);
  endtask

  task automatic test_err;
    logic [31:0] d, exp;
    logic a, e;
    logic [2:0] radr [4] = '{3'd4, 3'd5, 3'd2, 3'd3};
    bus_xfer(3'd7, 1'b0, 32'h0, 4'hF, d, a, e);
    n_checks++;
    if (e !== 1'b1 || a !== 1'b0 || d !== 32'h0 || bus.wb_err_o !== 1'b0) begin
      $display("FAIL err_read: err=%b ack=%b dat=%h err_after=%b, required 1 0 0 0",
               e, a, d, bus.wb_err_o);
    end else n_pass++;
    bus_xfer(3'd7, 1'b1, 32'hFFFF_FFFF, 4'hF, d, a, e);
    n_checks++;
    if (e !== 1'b1 || a !== 1'b0 || bus.wb_err_o !== 1'b0) begin
      $display("FAIL err_write: err=%b ack=%b err_after=%b, required 1 0 0", e, a, bus.wb_err_o);
    end else n_pass++;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1000);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      bus_xfer(radr[i], 1'b0, 32'h0, 4'hF, d, a, e);
      exp = exp_q.pop_front();
      n_checks++;
      if (d !== exp) $display("FAIL err_no_change[%0d]: got %h required %h", radr[i], d, exp);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ack_seq;
    logic [31:0] exp;
    wr(3'd5, 32'h5);
    bus.wb_adr_i = 3'd5;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'hF;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    exp_q.push_back(32'h5);
    exp_q.push_back(32'h5);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ack_seq[i] = bus.wb_ack_o;
      if (bus.wb_ack_o === 1'b1) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (bus.wb_dat_o !== exp) $display("FAIL b2b_data[%0d]: got %h required %h", i, bus.wb_dat_o, exp);
        else n_pass++;
      end
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ack_seq !== 4'b0101 || exp_q.size() != 0) begin
      $display("FAIL b2b_ack_pattern: got %b (left %0d) required 0101 (left 0)", ack_seq, exp_q.size());
      exp_q.delete();
    end else n_pass++;
    wr(3'd5, 32'h0);
  endtask

  task automatic test_async_reset;
    logic [31:0] d, exp;
    logic a, e;
    wr(3'd2, 32'h0);
    wr(3'd3, 32'h0);
    wr(3'd4, 32'd3);
    n_checks++;
    if (irq !== 1'b1) $display("FAIL pre_reset_irq: got %b required 1", irq);
    else n_pass++;
    bus.wb_adr_i = 3'd4;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'hF;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'h3) begin
      $display("FAIL pre_reset_ack: ack=%b dat=%h required ack=1 dat=3", bus.wb_ack_o, bus.wb_dat_o);
    end else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0 || irq !== 1'b0 || bus.wb_dat_o !== 32'h0) begin
      $display("FAIL async_reset: ack=%b err=%b irq=%b dat=%h, required all 0",
               bus.wb_ack_o, bus.wb_err_o, irq, bus.wb_dat_o);
    end else n_pass++;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(RST_VALS[i]);
      bus_xfer(3'(i), 1'b0, 32'h0, 4'hF, d, a, e);
      exp = exp_q.pop_front();
      n_checks++;
      if (d !== exp || a !== 1'b1) begin
        $display("FAIL post_reset_read[%0d]: dat=%h ack=%b, required dat=%h ack=1", i, d, a, exp);
      end else n_pass++;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    do_reset();
    test_reset();
    test_byte_lane();
    test_count();
    test_wrap();
    test_irq();
    test_err();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_mtimer.md
Name: wb_mtimer

Overview:
- Wishbone B3 classic slave: 64-bit RISC-V machine timer (mtime/mtimecmp) with prescaler and level timer interrupt.
- Hangs off the SoC Wishbone intercon as a peripheral next to uart0/gpio0; consumes the picorv32 master's routed cycles and drives the CPU timer IRQ line.
- Hardware source for tick and timeout services in firmware.

Parameters:
- PRESCALE_W, 16, width of prescaler register; tick every PRESCALE+1 wb_clk_i cycles
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp; default keeps IRQ deasserted

Ports:
- wb_clk_i  in  1  system clock, single clock domain
- wb_rst_ni  in  1  asynchronous active-low reset
- wb_adr_i  in  3  word address, connected to intercon adr[4:2]
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_dat_o  out  32  read data, valid with ack
- wb_ack_o  out  1  transfer acknowledge
- wb_err_o  out  1  error acknowledge
- irq_o  out  1  timer interrupt, level, registered

Behaviour:
- Reset (wb_rst_ni low, asynchronous): mtime=0, mtimecmp=CMP_RESET, ctrl=0, prescale=0, prescale counter=0, hi_shadow=0, wb_dat_o=0, wb_ack_o=0, wb_err_o=0, irq_o=0.
- Register map by wb_adr_i:
  - 0: MTIME_LO, rw
  - 1: MTIME_HI, rw
  - 2: MTIMECMP_LO, rw
  - 3: MTIMECMP_HI, rw
  - 4: CTRL, rw; bit0 EN, bit1 IRQ_EN, other bits read 0
  - 5: PRESCALE, rw; [PRESCALE_W-1:0], upper bits read 0
  - 6: STATUS, ro; bit0 PENDING = (mtime >= mtimecmp), unsigned 64-bit compare
  - 7: unmapped
- Handshake:
  - Request = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o.
  - Respond exactly 1 cycle after the request is first seen: ack (or err) is a single-cycle pulse; data is registered in that same cycle.
  - Master holding stb after ack starts the next access the cycle after ack drops, so sustained throughput is 1 transfer per 2 cycles.
  - Dropping cyc while ack is pending does not cancel the register-side effect, which was already captured on the request cycle.
- Writes: applied on the request cycle, per byte lane (wb_sel_i[n] gates bits 8n+7:8n).
  - Write to STATUS: acked, ignored.
  - Address 7: wb_err_o instead of ack, no state change, read data 0.
- Reads:
  - Reading MTIME_LO returns live low word and copies live mtime[63:32] into hi_shadow in the same cycle.
  - Reading MTIME_HI returns hi_shadow, never the live value. This gives a tear-free 64-bit read (LO then HI).
  - Address 7 read: err, dat 0.
- Counting:
  - With EN=1, prescale counter increments each cycle; at count==PRESCALE it clears and mtime increments by 1.
  - PRESCALE=0 means increment every cycle.
  - EN=0 freezes mtime and clears the prescale counter.
  - mtime wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
  - Carry from low to high word happens in the same cycle (single 64-bit adder).
- Simultaneous events:
  - A bus write to MTIME_LO/HI in a tick cycle: the written lanes take bus data, unwritten lanes take the incremented value. The next tick increments from the resulting value.
  - A write to PRESCALE takes effect on the next compare; the counter is not cleared.
- Interrupt:
  - irq_o registered: irq_o <= IRQ_EN & (mtime >= mtimecmp), using the current-cycle register values.
  - So irq_o lags the compare condition by 1 cycle.
  - Level sensitive; deasserts 1 cycle after firmware writes a larger mtimecmp or clears IRQ_EN.

Test Plan:
- Reset, then read addr 0,1,2,3,4 -> 0, 0, FFFF_FFFF, FFFF_FFFF, 0; each acked 1 cycle after stb; irq_o=0; err never asserted.
- Write PRESCALE=3, CTRL=1, wait 40 cycles from EN write -> MTIME_LO reads 10 (one tick per 4 cycles); EN=0 then wait 20 cycles -> value unchanged.
- Write MTIME_LO=FFFF_FFFE, MTIME_HI=0, PRESCALE=0, EN=1; read LO at the wrap boundary then HI -> HI equals the shadow captured with LO (0 or 1, consistent with LO); later reads show HI=1.
- mtimecmp=0x0000_0000_0000_0064, CTRL=3, mtime=0x50, PRESCALE=0 -> irq_o rises 1 cycle after mtime reaches 0x64; STATUS bit0=1; writing mtimecmp=0x1000 drops irq_o next cycle.
- Byte-lane write sel=4'b0010, dat=0x0000_AB00 to MTIMECMP_LO after reset -> reads FFFF_ABFF; write to STATUS -> ack, STATUS unchanged.
- Access addr 7 read and write -> wb_err_o pulse 1 cycle, ack stays 0, no register change; assert wb_rst_ni low mid-count -> all outputs and registers return to reset values immediately, without waiting for a clock edge.
